// File: rtl/pkt_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pkt_buf_ctrl
// Brief    : Store-and-forward packer/unpacker around an 80-bit show-ahead FIFO.
// Revision : 1.0
// ============================================================================
module pkt_buf_ctrl #(
    parameter int MAX_PKT_WORDS = 190,
    parameter int DEPTH         = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [2:0]  in_mod,
    input  logic        in_val,
    output logic [79:0] fifo_wdata,
    output logic        fifo_wval,
    input  logic [11:0] fifo_usedw,
    input  logic        fifo_full,
    input  logic [79:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_rval,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [2:0]  out_mod,
    output logic        out_err,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [11:0] pkt_avail,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [1:0]  W_IDLE    = 2'd0;
    localparam logic [1:0]  W_PASS    = 2'd1;
    localparam logic [1:0]  W_DROP    = 2'd2;
    localparam logic [11:0] ADMIT_MAX = 12'(DEPTH - MAX_PKT_WORDS - 2);
    localparam int          CW        = $clog2(MAX_PKT_WORDS + 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] wcnt, wcnt_nxt;
    logic          wr, wr_eop, wr_err, drop_inc, err_inc, space;
    logic          can_pop, pkt_inc, pkt_dec;
    logic          unused_bits;

    assign unused_bits = ^fifo_rdata[79:70];
    assign space       = (fifo_usedw <= ADMIT_MAX);

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        wr        = 1'b0;
        wr_eop    = in_eop;
        wr_err    = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        if (in_val) begin
            case (state)
                W_PASS: begin
                    wr = 1'b1;
                    if (in_sop) begin
                        // missing EOP: close the broken packet with this word
                        wr_eop    = 1'b1;
                        wr_err    = 1'b1;
                        err_inc   = 1'b1;
                        state_nxt = W_IDLE;
                    end else if (in_eop) begin
                        state_nxt = W_IDLE;
                    end else if (wcnt == CW'(MAX_PKT_WORDS - 1)) begin
                        wr_eop    = 1'b1;
                        wr_err    = 1'b1;
                        err_inc   = 1'b1;
                        state_nxt = W_DROP;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
                default: begin
                    if (in_sop) begin
                        if (space) begin
                            wr        = 1'b1;
                            wcnt_nxt  = CW'(1);
                            state_nxt = in_eop ? W_IDLE : W_PASS;
                        end else begin
                            drop_inc  = 1'b1;
                            state_nxt = in_eop ? W_IDLE : W_DROP;
                        end
                    end else if (state == W_DROP) begin
                        if (in_eop) state_nxt = W_IDLE;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            endcase
        end
        if (wr && fifo_full) begin
            wr      = 1'b0;
            err_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= W_IDLE;
            wcnt       <= '0;
            fifo_wdata <= '0;
            fifo_wval  <= 1'b0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            wcnt      <= wcnt_nxt;
            fifo_wval <= wr;
            if (wr) fifo_wdata <= {10'd0, wr_err, in_mod, wr_eop, in_sop, in_data};
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    // Only whole packets are released: popping waits for a committed EOP.
    assign can_pop   = !fifo_empty && (pkt_avail != 12'd0);
    assign fifo_rval = can_pop && (!out_val || out_rdy);
    assign pkt_inc   = fifo_wval && fifo_wdata[65];
    assign pkt_dec   = fifo_rval && fifo_rdata[65];

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_avail <= '0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_mod   <= '0;
            out_err   <= 1'b0;
            out_val   <= 1'b0;
        end else begin
            if (pkt_inc && !pkt_dec) pkt_avail <= pkt_avail + 12'd1;
            else if (!pkt_inc && pkt_dec) pkt_avail <= pkt_avail - 12'd1;
            if (fifo_rval) begin
                out_data <= fifo_rdata[63:0];
                out_sop  <= fifo_rdata[64];
                out_eop  <= fifo_rdata[65];
                out_mod  <= fifo_rdata[68:66];
                out_err  <= fifo_rdata[69];
                out_val  <= 1'b1;
            end else if (out_rdy) begin
                out_val <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_buf_ctrl
// Brief    : Scoreboard bench for pkt_buf_ctrl with a behavioural show-ahead FIFO.
// Revision : 1.0
// ============================================================================
module tb_pkt_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data;
    logic        in_sop, in_eop, in_val;
    logic [2:0]  in_mod;
    logic [79:0] fifo_wdata;
    logic        fifo_wval;
    logic [11:0] fifo_usedw;
    logic        fifo_full;
    logic [79:0] fifo_rdata = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rval;
    logic [63:0] out_data;
    logic        out_sop, out_eop, out_err, out_val, out_rdy;
    logic [2:0]  out_mod;
    logic [11:0] pkt_avail;
    logic [15:0] drop_cnt, err_cnt;

    logic [79:0] fq[$];
    logic [69:0] sb[$];
    int fifo_cnt   = 0;
    int usedw_bias = 0;
    int wr_count   = 0;
    int acc_cnt    = 0;
    int n_chk      = 0;
    int n_pass     = 0;

    always #5 clk = ~clk;

    pkt_buf_ctrl dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod), .in_val(in_val),
        .fifo_wdata(fifo_wdata), .fifo_wval(fifo_wval), .fifo_usedw(fifo_usedw),
        .fifo_full(fifo_full), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .fifo_rval(fifo_rval),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_mod(out_mod),
        .out_err(out_err), .out_val(out_val), .out_rdy(out_rdy),
        .pkt_avail(pkt_avail), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    assign fifo_usedw = 12'(fifo_cnt + usedw_bias);
    assign fifo_full  = (fifo_cnt >= 2048);

    // Show-ahead FIFO model sharing the DUT reset
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
        end else begin
            if (fifo_rval && fq.size() != 0) void'(fq.pop_front());
            if (fifo_wval && !fifo_full) begin
                fq.push_back(fifo_wdata);
                wr_count++;
            end
        end
        fifo_cnt   <= fq.size();
        fifo_empty <= (fq.size() == 0);
        fifo_rdata <= (fq.size() != 0) ? fq[0] : 80'd0;
    end

    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (!rst && out_val && out_rdy) begin
            acc_cnt++;
            if (sb.size() == 0) check("unexpected_out", 80'd1, 80'd0);
            else check("out_word", 80'({out_err, out_mod, out_eop, out_sop, out_data}),
                       80'(sb.pop_front()));
        end
    end

    function automatic logic [69:0] ent(input logic err, input logic [2:0] mod,
                                        input logic eop, input logic sop, input logic [63:0] d);
        return {err, mod, eop, sop, d};
    endfunction

    task automatic drive(input logic sop, input logic eop, input logic [2:0] mod,
                         input logic [63:0] d);
        @(posedge clk);
        #1;
        in_val = 1'b1; in_sop = sop; in_eop = eop; in_mod = mod; in_data = d;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int id, input int n, input logic [2:0] mod);
        logic s, e;
        logic [2:0] m;
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            s = (i == 0);
            e = (i == n - 1);
            m = e ? mod : 3'd0;
            d = {32'(id), 32'(i)};
            drive(s, e, m, d);
            sb.push_back(ent(1'b0, m, e, s, d));
        end
        idle();
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check(tag, 80'(sb.size()), 80'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, w0, base;
        logic [63:0] d;
        in_val = 0; in_sop = 0; in_eop = 0; in_mod = 0; in_data = 0; out_rdy = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wval",  80'(fifo_wval), 80'd0);
        check("rst_wdata", fifo_wdata, 80'd0);
        check("rst_rval",  80'(fifo_rval), 80'd0);
        check("rst_out",   80'({out_val, out_sop, out_eop, out_err, out_mod, out_data}), 80'd0);
        check("rst_avail", 80'(pkt_avail), 80'd0);
        check("rst_drop",  80'(drop_cnt), 80'd0);
        check("rst_err",   80'(err_cnt), 80'd0);
        rst = 1'b0;
        out_rdy = 1'b1;

        // single-word packet, mod=5
        drive(1'b1, 1'b1, 3'd5, 64'hA5A5_0000_0000_0001);
        sb.push_back(ent(1'b0, 3'd5, 1'b1, 1'b1, 64'hA5A5_0000_0000_0001));
        idle();
        check("t1_wval",   80'(fifo_wval), 80'd1);
        check("t1_flags",  80'(fifo_wdata[69:64]), 80'(6'b010111));
        check("t1_avail0", 80'(pkt_avail), 80'd0);
        @(posedge clk); #1;
        check("t1_avail1", 80'(pkt_avail), 80'd1);
        check("t1_rval",   80'(fifo_rval), 80'd1);
        @(posedge clk); #1;
        check("t1_outval", 80'(out_val), 80'd1);
        check("t1_avail2", 80'(pkt_avail), 80'd0);
        wait_drain("t1_drain");

        // full-length packet held until EOP is committed, then streamed
        out_rdy = 1'b0;
        send_pkt(2, 190, 3'd2);
        check("t2_noval",  80'(out_val), 80'd0);
        check("t2_avail0", 80'(pkt_avail), 80'd0);
        @(posedge clk); #1;
        check("t2_avail1", 80'(pkt_avail), 80'd1);
        @(posedge clk); #1;
        check("t2_head",   80'(out_val), 80'd1);
        out_rdy = 1'b1;
        base = acc_cnt;
        repeat (190) @(posedge clk);
        #1;
        check("t2_b2b",    80'(acc_cnt - base), 80'd190);
        check("t2_avail2", 80'(pkt_avail), 80'd0);
        wait_drain("t2_drain");

        // 191-word packet is truncated at word 190
        e0 = int'(err_cnt);
        for (int i = 0; i < 191; i++) begin
            d = {32'd3, 32'(i)};
            drive(i == 0, i == 190, 3'd0, d);
            if (i < 189) sb.push_back(ent(1'b0, 3'd0, 1'b0, i == 0, d));
            else if (i == 189) sb.push_back(ent(1'b1, 3'd0, 1'b1, 1'b0, d));
        end
        idle();
        @(posedge clk); #1;
        check("t3_err", 80'(err_cnt), 80'(e0 + 1));
        send_pkt(4, 3, 3'd7);
        wait_drain("t3_drain");
        check("t3_err_after", 80'(err_cnt), 80'(e0 + 1));

        // admission threshold
        usedw_bias = 1857;
        w0 = wr_count;
        drive(1'b1, 1'b0, 3'd0, 64'h5);
        drive(1'b0, 1'b1, 3'd1, 64'h6);
        idle();
        repeat (2) @(posedge clk); #1;
        check("t4_drop",    80'(drop_cnt), 80'd1);
        check("t4_nowrite", 80'(wr_count - w0), 80'd0);
        check("t4_avail",   80'(pkt_avail), 80'd0);
        usedw_bias = 1856;
        send_pkt(6, 2, 3'd1);
        usedw_bias = 0;
        wait_drain("t4_drain");
        check("t4_accept",  80'(wr_count - w0), 80'd2);
        check("t4_drop2",   80'(drop_cnt), 80'd1);

        // SOP arrives while a packet is open
        e0 = int'(err_cnt);
        for (int i = 0; i < 3; i++) begin
            d = {32'd7, 32'(i)};
            drive(i == 0, 1'b0, 3'd0, d);
            sb.push_back(ent(1'b0, 3'd0, 1'b0, i == 0, d));
        end
        drive(1'b1, 1'b1, 3'd4, 64'h77);
        sb.push_back(ent(1'b1, 3'd4, 1'b1, 1'b1, 64'h77));
        idle();
        @(posedge clk); #1;
        check("t5_err", 80'(err_cnt), 80'(e0 + 1));
        send_pkt(8, 2, 3'd3);
        wait_drain("t5_drain");
        check("t5_err_after", 80'(err_cnt), 80'(e0 + 1));

        // reset mid-packet with three committed packets waiting
        out_rdy = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(9 + p, 1, 3'd1);
        repeat (3) @(posedge clk); #1;
        check("t6_avail3", 80'(pkt_avail), 80'd3);
        check("t6_held",   80'(out_val), 80'd1);
        drive(1'b1, 1'b0, 3'd0, 64'hDEAD);
        drive(1'b0, 1'b0, 3'd0, 64'hBEEF);
        in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("t6_wval",  80'(fifo_wval), 80'd0);
        check("t6_wdata", fifo_wdata, 80'd0);
        check("t6_rval",  80'(fifo_rval), 80'd0);
        check("t6_out",   80'({out_val, out_sop, out_eop, out_err, out_mod, out_data}), 80'd0);
        check("t6_avail", 80'(pkt_avail), 80'd0);
        check("t6_cnts",  80'({drop_cnt, err_cnt}), 80'd0);
        rst = 1'b0;
        out_rdy = 1'b1;
        send_pkt(13, 4, 3'd6);
        wait_drain("t6_drain");
        check("t6_err_after", 80'(err_cnt), 80'd0);
        check("t6_avail_end", 80'(pkt_avail), 80'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_buf_ctrl.md
# pkt_buf_ctrl

Store-and-forward controller for the 80-bit x 2048-word packet buffer FIFO in the L8 packet buffer stage. It takes a 64-bit frame stream with no backpressure from the receive path and packs each word with its framing flags into one FIFO entry. Admission is decided per packet at SOP from FIFO occupancy, and the block releases a packet downstream only once its EOP is in the FIFO. Downstream therefore always sees whole packets back-to-back.

## Interface
- MAX_PKT_WORDS, 190, longest legal packet in 64-bit words; longer packets are truncated
- DEPTH, 2048, FIFO depth in words
- clk  in  1  clock for all logic
- rst  in  1  synchronous, active-high reset
- in_data  in  64  receive data
- in_sop / in_eop  in  1/1  frame start / end flags
- in_mod  in  3  valid bytes in EOP word; 0 means 8
- in_val  in  1  word valid; no ready signal exists, so the upstream cannot be stalled
- fifo_wdata  out  80  packed entry: [63:0] data, [64] sop, [65] eop, [68:66] mod, [69] err, [79:70] zero
- fifo_wval  out  1  FIFO write strobe
- fifo_usedw  in  12  FIFO occupancy
- fifo_full  in  1  FIFO full
- fifo_rdata  in  80  head entry; the FIFO is configured show-ahead
- fifo_empty  in  1  FIFO empty
- fifo_rval  out  1  pop the head entry
- out_data  out  64, out_sop / out_eop  out  1/1, out_mod  out  3, out_err  out  1  output fields
- out_val  out  1, out_rdy  in  1  output valid/ready handshake
- pkt_avail  out  12  committed packets not yet fully popped from the FIFO
- drop_cnt / err_cnt  out  16/16  saturating statistics counters

## Operation
- Write FSM states: W_IDLE, W_PASS, W_DROP. Reset state is W_IDLE.
- The FIFO write is registered. fifo_wdata and fifo_wval are driven on the cycle after the input word arrives.
- Admission rule: accept when fifo_usedw <= DEPTH - MAX_PKT_WORDS - 2. The margin of 2 covers the usedw lag.
- W_IDLE behaviour:
  - in_val with in_sop and space available: write the word. If in_eop is also set, stay in W_IDLE; otherwise go to W_PASS.
  - in_val with in_sop and no space: drop_cnt++. Go to W_DROP unless in_eop is set.
  - in_val without in_sop: discard the word, err_cnt++.
- W_PASS behaviour:
  - Write every in_val word and keep a word count.
  - On in_eop, go to W_IDLE.
  - Word number MAX_PKT_WORDS without in_eop: write it with eop=1, err=1, err_cnt++, go to W_DROP.
  - in_sop received (missing EOP): write that word with eop=1, err=1 to close the broken packet, err_cnt++, go to W_IDLE. The new packet is lost.
- W_DROP behaviour: discard words until in_eop, then go to W_IDLE. An in_sop in W_DROP is treated as in W_IDLE on the same cycle.
- fifo_full seen during a write cycle: suppress the write, err_cnt++. Design margin means this never occurs in normal operation.
- pkt_avail behaviour:
  - +1 on each FIFO write with eop=1.
  - -1 on each pop of an entry with eop=1.
  - Both in the same cycle: no change.
  - Never wraps, since every packet occupies at least one FIFO entry.
- Read side:
  - can_pop = !fifo_empty && pkt_avail != 0.
  - fifo_rval = can_pop && (!out_val || out_rdy).
  - The popped entry loads the output register stage on the next edge.
- Output register: holds its value while out_val && !out_rdy. out_val clears when the current word is accepted and no pop occurs in that cycle.
- Counters drop_cnt and err_cnt saturate at 0xFFFF.
- Reset: asserting rst mid-packet returns the FSM to W_IDLE and clears pkt_avail, both counters, the output stage and the write register. The FIFO must be reset by the same rst in the same cycle.
- Reset values: all outputs are 0 (fifo_wdata, fifo_wval, fifo_rval, out_*, pkt_avail, drop_cnt, err_cnt).

## Timing
- Input word to FIFO write: 1 cycle.
- EOP write to pkt_avail increment: 1 cycle.
- Pop to out_val: 1 cycle.
- Minimum input EOP to first output of a single-word packet: 3 cycles plus the FIFO's write-to-not-empty latency.
- Sustained throughput: 1 word per clock on both sides while out_rdy=1.
- The admission decision uses only fifo_usedw sampled in the SOP cycle.

## Test plan
- Single 1-word packet (sop=eop=1, mod=5) into an empty FIFO -> one entry with [69:64]=6'b010111. out_val goes high with out_sop=out_eop=1, out_mod=5. pkt_avail goes 0 -> 1 -> 0.
- 190-word packet streamed while out_rdy=0 -> out_val stays 0 until the EOP is written, pkt_avail=1. Raising out_rdy then yields 190 back-to-back words with only the last having out_eop=1.
- 191-word packet -> word 190 is written with eop=1, err=1, word 191 is discarded, err_cnt=1, next packet passes cleanly.
- Preload fifo_usedw to 1857 (> 2048-190-2), then send a packet -> drop_cnt=1 and no FIFO writes. The next packet sent at usedw=1856 is accepted.
- SOP arrives mid-packet in W_PASS -> the broken packet is closed with err=1, err_cnt=1, FSM returns to W_IDLE.
- Assert rst during W_PASS with pkt_avail=3 -> the next cycle shows all outputs 0 and FSM in W_IDLE. A following packet passes intact.
